// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - select sequencer for the 4:1 mux
// Scans enabled channels in ascending order, holds each DWELL cycles, captures f_in into frame.
module mux_sel_sequencer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       f_in,
  output logic [1:0] s,
  output logic       sample,
  output logic [3:0] frame,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       mask_q;
  logic [1:0]       first_idx, next_idx;
  logic             next_valid;
  logic             last;

  assign last   = (cnt == CNT_W'(DWELL - 1));
  assign busy   = (state == SCAN);
  assign done   = (state == DONE);
  assign sample = (state == SCAN) && last;

  // Descending loops so the final hit is the lowest qualifying channel.
  always_comb begin
    first_idx  = 2'd0;
    next_idx   = 2'd0;
    next_valid = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k]) first_idx = 2'(k);
      if (mask_q[k] && (k > int'(s))) begin
        next_idx   = 2'(k);
        next_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (|mask) ? SCAN : DONE;
      SCAN: if (last && !next_valid) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s      <= 2'b00;
      frame  <= 4'b0000;
      cnt    <= '0;
      mask_q <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            frame <= 4'b0000;
            cnt   <= '0;
            if (|mask) begin
              mask_q <= mask;
              s      <= first_idx;
            end
          end
        end
        SCAN: begin
          if (last) begin
            frame[s] <= f_in;
            cnt      <= '0;
            if (next_valid) s <= next_idx;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb/tb_mux_sel_sequencer.sv - directed bench for mux_sel_sequencer
// Three instances cover DWELL=4, 2 and 1; each has its own start and mux inputs.
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] mask = 4'b0000;
  logic       start4 = 1'b0, start2 = 1'b0, start1 = 1'b0;
  logic [3:0] inp4 = 4'b0000, inp2 = 4'b0000, inp1 = 4'b0000;

  logic [1:0] s4, s2, s1;
  logic       sample4, sample2, sample1;
  logic [3:0] frame4, frame2, frame1;
  logic       busy4, busy2, busy1;
  logic       done4, done2, done1;
  logic       f4, f2, f1;

  assign f4 = inp4[s4];
  assign f2 = inp2[s2];
  assign f1 = inp1[s1];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_sel_sequencer #(.DWELL(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mask(mask), .f_in(f4),
    .s(s4), .sample(sample4), .frame(frame4), .busy(busy4), .done(done4));
  mux_sel_sequencer #(.DWELL(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mask(mask), .f_in(f2),
    .s(s2), .sample(sample2), .frame(frame2), .busy(busy2), .done(done2));
  mux_sel_sequencer #(.DWELL(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mask(mask), .f_in(f1),
    .s(s1), .sample(sample1), .frame(frame1), .busy(busy1), .done(done1));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packs s, sample, busy, done of the DWELL=4 instance into one value.
  function automatic logic [7:0] st4();
    return {3'b000, s4, sample4, busy4, done4};
  endfunction
  function automatic logic [7:0] st2();
    return {3'b000, s2, sample2, busy2, done2};
  endfunction
  function automatic logic [7:0] st1();
    return {3'b000, s1, sample1, busy1, done1};
  endfunction

  initial begin
    // Reset values
    #2;
    check("rst0_st4", st4(), 8'h00);
    check("rst0_frame4", {4'h0, frame4}, 8'h00);
    tick(); rst_n = 1'b1;
    tick(); tick();
    rst_n = 1'b0; #1;
    check("rst_idle_st4", st4(), 8'h00);
    check("rst_idle_frame4", {4'h0, frame4}, 8'h00);
    check("rst_idle_st2", st2(), 8'h00);
    check("rst_idle_st1", st1(), 8'h00);
    tick(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_st4_%0d", i), st4(), 8'h00);
    end

    // Full scan, DWELL=4, mask 1111, i0..i3 = 1,0,1,1
    inp4 = 4'b1101; mask = 4'b1111; start4 = 1'b1;
    tick(); start4 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("full_st_c%0d", c), st4(),
            {3'b000, 2'((c - 1) / 4), (c % 4 == 0), 1'b1, 1'b0});
      tick();
    end
    check("full_done", st4(), {3'b000, 2'd3, 1'b0, 1'b0, 1'b1});
    check("full_frame", {4'h0, frame4}, 8'h0D);
    tick();
    check("full_after_done", {7'h0, done4}, 8'h00);

    // Sparse mask, DWELL=2, mask 1010, i1=1 i3=1
    inp2 = 4'b1010; mask = 4'b1010; start2 = 1'b1;
    tick(); start2 = 1'b0;
    check("sparse_s_c1", {6'h0, s2}, 8'h01);
    check("sparse_smp_c1", {7'h0, sample2}, 8'h00);
    tick();
    check("sparse_s_c2", {6'h0, s2}, 8'h01);
    check("sparse_smp_c2", {7'h0, sample2}, 8'h01);
    tick();
    check("sparse_s_c3", {6'h0, s2}, 8'h03);
    tick();
    check("sparse_s_c4", {6'h0, s2}, 8'h03);
    check("sparse_busy_c4", {7'h0, busy2}, 8'h01);
    tick();
    check("sparse_done", {6'h0, busy2, done2}, 8'h01);
    check("sparse_frame", {4'h0, frame2}, 8'h0A);
    tick();

    // Empty mask: straight to DONE, previous frame cleared
    mask = 4'b0000; start4 = 1'b1;
    tick(); start4 = 1'b0;
    check("empty_done", {6'h0, busy4, done4}, 8'h01);
    check("empty_frame", {4'h0, frame4}, 8'h00);
    tick();
    check("empty_after", {6'h0, busy4, done4}, 8'h00);

    // start held through a DWELL=2 scan: exactly one completion
    inp2 = 4'b0110; mask = 4'b1111; start2 = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("held_busy_c%0d", c), {6'h0, busy2, done2}, 8'h02);
      tick();
    end
    check("held_done", {6'h0, busy2, done2}, 8'h01);
    check("held_frame", {4'h0, frame2}, 8'h06);
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("held_idle_%0d", i), {6'h0, busy2, done2}, 8'h00);
    end

    // Reset mid-scan at s=10, then a clean rescan
    inp4 = 4'b0111; mask = 4'b1111; start4 = 1'b1;
    tick(); start4 = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    check("abort_pre_s", {6'h0, s4}, 8'h02);
    rst_n = 1'b0; #1;
    check("abort_st", st4(), 8'h00);
    check("abort_frame", {4'h0, frame4}, 8'h00);
    tick(); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("abort_nodone_%0d", i), {6'h0, busy4, done4}, 8'h00);
    end
    start4 = 1'b1;
    tick(); start4 = 1'b0;
    check("rescan_s0", st4(), 8'h02);
    for (int c = 1; c < 17; c++) tick();
    check("rescan_done", {6'h0, busy4, done4}, 8'h01);
    check("rescan_frame", {4'h0, frame4}, 8'h07);
    tick();

    // DWELL=1, mask 0111, mask widened mid-scan must not matter
    inp1 = 4'b1101; mask = 4'b0111; start1 = 1'b1;
    tick(); start1 = 1'b0; mask = 4'b1111;
    check("d1_c1", st1(), {3'b000, 2'd0, 1'b1, 1'b1, 1'b0});
    tick();
    check("d1_c2", st1(), {3'b000, 2'd1, 1'b1, 1'b1, 1'b0});
    tick();
    check("d1_c3", st1(), {3'b000, 2'd2, 1'b1, 1'b1, 1'b0});
    tick();
    check("d1_done", {6'h0, busy1, done1}, 8'h01);
    check("d1_frame", {4'h0, frame1}, 8'h05);
    tick();
    check("d1_idle", {6'h0, busy1, done1}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Upstream control stage for the 4:1 case-statement multiplexer.
- Drives the mux select `s`, scans the enabled input channels in ascending order, and holds each channel for a programmable dwell time.
- Captures the mux output `f` at the end of each dwell into a 4-bit frame register.
- Start/busy/done handshake toward the controlling logic.

Parameters:
- DWELL, 4, cycles `s` is held per channel before capture; legal range 1..255.
- CNT_W, 8, dwell counter width; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  scan request; sampled only in IDLE.
- mask  input  4  channel enable, bit k = channel k (i0..i3); latched on accepted start.
- f_in  input  1  mux output `f` fed back for capture.
- s  output  2  mux select, registered.
- sample  output  1  high during the final dwell cycle of the current channel (capture cycle).
- frame  output  4  captured values, bit k = value of channel k.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, rst_n=0) forces:
  - state=IDLE, s=2'b00, frame=4'b0000, cnt=0, mask_q=0.
  - busy=0, done=0, sample=0.
  - Takes effect immediately, including mid-scan. A scan aborted by reset never pulses done.
- States: IDLE, SCAN, DONE.
- IDLE, start=1 and mask!=0:
  - mask_q<=mask, frame<=0, cnt<=0.
  - s<=index of lowest set bit of mask.
  - Go to SCAN.
- IDLE, start=1 and mask==0: frame<=0, go to DONE (no scan).
- IDLE, start=0: hold all outputs. frame keeps its last result.
- SCAN:
  - busy=1. s is stable for exactly DWELL cycles per channel.
  - cnt increments every cycle.
  - sample = (cnt==DWELL-1), decoded from registers.
  - On the edge where cnt==DWELL-1:
    - frame[s]<=f_in, cnt<=0.
    - s<=next higher set bit of mask_q. If none remains, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE.
- start is ignored in SCAN and DONE. No queuing.
- Changes to mask after acceptance are ignored until the next start.
- Disabled channels are never selected; their frame bits read 0.
- DWELL=1: sample is high on every SCAN cycle and s advances every cycle.
- Channel order is strictly ascending (0→3). There is no wrap-around within a scan.
- Latency: start accepted at edge E0 → SCAN for N*DWELL cycles (N = popcount(mask)) → done high in the cycle after edge E0+N*DWELL.
- frame is stable and valid from the done cycle until the next accepted start.
- f_in must be settled while sample=1. The mux is combinational, so s-to-f_in settling occurs within the same cycle.

Test Plan:
- Reset values: assert rst_n=0 mid-idle → s=00, frame=0000, busy=0, done=0, sample=0. Release reset → all hold until start.
- Full scan: DWELL=4, mask=1111, mux inputs i0..i3=1,0,1,1, pulse start.
  - s steps 00,01,10,11, each held 4 cycles.
  - sample high on cycles 4, 8, 12, 16 after start.
  - busy high for 16 cycles, then done for 1 cycle, with frame=4'b1101.
- Sparse mask: mask=1010, DWELL=2, i1=1, i3=1.
  - s shows only 01 then 11, 2 cycles each.
  - done 4 cycles after the start edge, frame=4'b1010.
- Empty mask and ignored start: mask=0000 with start → no SCAN, busy stays 0, done pulses 1 cycle after start, frame=0000. start held high during SCAN → does not restart; the scan completes exactly once.
- Reset mid-scan: assert rst_n=0 while s=10 during a 1111 scan → outputs return to reset values immediately, no done pulse. A subsequent start runs a clean scan from channel 0.
- DWELL=1 and mask change: mask=0111, DWELL=1 → s=00,01,10 on consecutive cycles, sample high all 3 cycles, done on the 4th cycle. Changing mask mid-scan has no effect.
